// File: rtl/om_pkg.sv
// Shared definitions for the online-multiplier selection stage: digit codes,
// FSM state encoding and a digit decode helper.
package om_pkg;

  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;
  localparam logic [1:0] DIG_ZERO = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // {p,n} borrow-save digit to its signed value; 11 is never produced and decodes as 0.
  function automatic logic signed [1:0] dig_val(input logic [1:0] d);
    case (d)
      DIG_POS: dig_val = 2'sb01;
      DIG_NEG: dig_val = 2'sb11;
      default: dig_val = 2'sb00;
    endcase
  endfunction

endpackage

// File: rtl/om_csa42.sv
// 4:2 carry-save compressor built from two 3:2 layers; all arithmetic is mod 2^W.
module om_csa42 #(
  parameter int W = 6
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  logic [W-1:0] s1, maj1, c1, maj2;

  assign s1   = a_i ^ b_i ^ c_i;
  assign maj1 = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign c1   = maj1 << 1;

  assign sum_o   = s1 ^ c1 ^ d_i;
  assign maj2    = (s1 & c1) | (s1 & d_i) | (c1 & d_i);
  assign carry_o = maj2 << 1;

endmodule

// File: rtl/om_sel_stage.sv
// Radix-2 online-multiplier selection/residual stage: absorbs (ws_in, wc_in) per
// accept, selects one digit in {-1,0,+1} MSD first. Optional check: OM_SEL_OVF_CHK_EN.
module om_sel_stage
  import om_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int DELTA    = 2,
  parameter int W        = 6,
  parameter int EST_BITS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] ws_in,
  input  logic [W-1:0] wc_in,
  output logic [1:0]   z_out,
  output logic         z_valid,
  output logic         z_last,
  output logic         busy,
  output logic         done,
  output logic         ovf
);

  localparam int CNT_W = $clog2(N_DIGITS + 1);
  localparam logic signed [EST_BITS-1:0] EST_HI = EST_BITS'(2);
  localparam logic signed [EST_BITS-1:0] EST_LO = -EST_BITS'(2);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [W-1:0]       ws_q, wc_q;
  logic [1:0]         z_q;
  logic               z_valid_q, z_last_q, done_q;

  logic [W-1:0]               vs, vc, vsum;
  logic signed [W-1:0]        zw, resid;
  logic signed [EST_BITS-1:0] est;
  logic [1:0]                 dig_sel, dig_c;
  logic                       accept;

  om_csa42 #(.W(W)) u_csa (
    .a_i     (ws_q << 1),
    .b_i     (wc_q << 1),
    .c_i     (ws_in),
    .d_i     (wc_in),
    .sum_o   (vs),
    .carry_o (vc)
  );

  assign vsum = vs + vc;
  assign est  = vsum[W-1 -: EST_BITS];

  always_comb begin
    dig_sel = DIG_ZERO;
    if (est >= EST_HI)     dig_sel = DIG_POS;
    else if (est < EST_LO) dig_sel = DIG_NEG;
  end

  assign dig_c  = (state_q == RUN) ? dig_sel : DIG_ZERO;
  // A digit of 1.0 sits at bit W-2 (two integer bits above the fraction).
  assign zw     = W'(dig_val(dig_c)) <<< (W - 2);
  assign resid  = vsum - zw;
  assign accept = in_valid & in_ready;

  assign in_ready = (state_q == FILL) || (state_q == RUN);
  assign busy     = (state_q != IDLE);
  assign z_out    = z_q;
  assign z_valid  = z_valid_q;
  assign z_last   = z_last_q;
  assign done     = done_q;

`ifdef OM_SEL_OVF_CHK_EN
  logic ovf_q;
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ws_q      <= '0;
      wc_q      <= '0;
      z_q       <= DIG_ZERO;
      z_valid_q <= 1'b0;
      z_last_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef OM_SEL_OVF_CHK_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      z_valid_q <= 1'b0;
      z_last_q  <= 1'b0;
      done_q    <= 1'b0;
      if (accept) begin
        // Residual is re-normalised into ws after selection; wc restarts at 0.
        ws_q <= resid;
        wc_q <= '0;
`ifdef OM_SEL_OVF_CHK_EN
        if (resid[W-1] != resid[W-2]) ovf_q <= 1'b1;
`endif
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FILL;
            cnt_q   <= '0;
            ws_q    <= '0;
            wc_q    <= '0;
`ifdef OM_SEL_OVF_CHK_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        FILL: begin
          if (accept) begin
            z_q <= DIG_ZERO;
            if (cnt_q == CNT_W'(DELTA - 1)) begin
              state_q <= RUN;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        RUN: begin
          if (accept) begin
            z_q       <= dig_c;
            z_valid_q <= 1'b1;
            if (cnt_q == CNT_W'(N_DIGITS - 1)) begin
              z_last_q <= 1'b1;
              state_q  <= DONE;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_om_sel_stage.sv
// Bench for om_sel_stage: randomized operations against an integer residual model.
module tb_om_sel_stage;

  localparam int N     = 8;
  localparam int DELTA = 2;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic [5:0] ws_in, wc_in;
  logic       in_ready, z_valid, z_last, busy, done, ovf;
  logic [1:0] z_out;

  int checks = 0;
  int failures = 0;

  // Reference model: phase 0 idle, 1 accepting, 2 final one-cycle wrap-up.
  int         m_ph = 0;
  int         m_acc = 0;
  int         m_r = 0;
  logic [1:0] m_z = 2'b00;
  logic       m_ovf = 1'b0;

  om_sel_stage dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .ws_in(ws_in), .wc_in(wc_in), .z_out(z_out), .z_valid(z_valid), .z_last(z_last),
    .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic int wrap6(input int x);
    int y;
    y = ((x % 64) + 64) % 64;
    return (y >= 32) ? y - 64 : y;
  endfunction

  function automatic int sx(input logic [5:0] v);
    return v[5] ? int'(v) - 64 : int'(v);
  endfunction

  // One clock: drive inputs at negedge, advance the model, return expectations for after the edge.
  task automatic cycle(input logic st, input logic v, input logic [5:0] ws, input logic [5:0] wc,
                       output logic [5:0] e_stat, output logic [1:0] e_z);
    int vv, est, zi;
    logic e_zv, e_zl, e_done, e_ovf;
    @(negedge clk);
    start = st; in_valid = v; ws_in = ws; wc_in = wc;
    e_zv = 1'b0; e_zl = 1'b0; e_done = 1'b0;
    if (m_ph == 0) begin
      if (st) begin m_ph = 1; m_acc = 0; m_r = 0; m_ovf = 1'b0; end
    end else if (m_ph == 1) begin
      if (v) begin
        m_acc++;
        vv  = wrap6(2 * m_r + sx(ws) + sx(wc));
        est = vv >>> 2;
        zi  = 0;
        if (m_acc > DELTA) begin
          if (est >= 2) zi = 1;
          else if (est < -2) zi = -1;
        end
        m_r = wrap6(vv - 16 * zi);
        if (m_r >= 16 || m_r < -16) m_ovf = 1'b1;
        if (m_acc > DELTA) begin
          e_zv = 1'b1;
          m_z = (zi == 1) ? 2'b10 : (zi == -1) ? 2'b01 : 2'b00;
        end else begin
          m_z = 2'b00;
        end
        if (m_acc == DELTA + N) begin e_zl = 1'b1; m_ph = 2; end
      end
    end else begin
      m_ph = 0;
      e_done = 1'b1;
    end
`ifdef OM_SEL_OVF_CHK_EN
    e_ovf = m_ovf;
`else
    e_ovf = 1'b0;
`endif
    e_stat = {e_zv, e_zl, e_done, m_ph != 0, m_ph == 1, e_ovf};
    e_z = m_z;
    @(posedge clk);
    #1;
  endtask

  // One full operation; digits seen on z_valid are returned for scenario-specific checks.
  task automatic run_op(input string tag, input logic [5:0] first_ws, input bit rnd,
                        input int stall_at, input int stall_len,
                        output logic [1:0] dig [N], output int nd);
    logic [5:0] es;
    logic [1:0] ez;
    logic [5:0] ws, wc;
    logic v, st;
    int acc, stalled, cyc;
    nd = 0; acc = 0; stalled = 0; cyc = 0;
    for (int i = 0; i < N; i++) dig[i] = 2'b00;
    cycle(1'b1, 1'b1, 6'h1f, 6'h00, es, ez);
    checks++;
    if ({busy, in_ready} !== 2'b11) begin
      failures++;
      $display("FAIL %s start: busy,in_ready=%b expected 11", tag, {busy, in_ready});
    end
    while (acc < DELTA + N && cyc < 200) begin
      cyc++;
      if (acc == stall_at && stalled < stall_len) begin v = 1'b0; stalled++; end
      else if (rnd) v = ($urandom_range(0, 3) != 0);
      else v = 1'b1;
      st = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rnd) begin ws = 6'($urandom); wc = 6'($urandom); end
      else begin ws = (acc == 0) ? first_ws : 6'h00; wc = 6'h00; end
      cycle(st, v, ws, wc, es, ez);
      if (v) acc++;
      checks++;
      if ({z_valid, z_last, done, busy, in_ready, ovf} !== es) begin
        failures++;
        $display("FAIL %s status acc=%0d: zv,zl,done,busy,rdy,ovf=%b expected %b",
                 tag, acc, {z_valid, z_last, done, busy, in_ready, ovf}, es);
      end
      if (es[5]) begin
        checks++;
        if (z_out !== ez) begin
          failures++;
          $display("FAIL %s digit %0d: z_out=%b expected %b", tag, nd, z_out, ez);
        end
      end
      if (z_valid === 1'b1 && nd < N) begin dig[nd] = z_out; nd++; end
    end
    if (cyc >= 200) begin
      checks++; failures++;
      $display("FAIL %s timeout: accepts=%0d expected %0d", tag, acc, DELTA + N);
    end
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, 6'h00, 6'h00, es, ez);
      checks++;
      if ({z_valid, z_last, done, busy, in_ready, ovf} !== es) begin
        failures++;
        $display("FAIL %s tail%0d: zv,zl,done,busy,rdy,ovf=%b expected %b",
                 tag, k, {z_valid, z_last, done, busy, in_ready, ovf}, es);
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; ws_in = 6'h00; wc_in = 6'h00;
    repeat (n) @(posedge clk);
    #1;
    m_ph = 0; m_acc = 0; m_r = 0; m_z = 2'b00; m_ovf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++;
    if ({z_out, z_valid, z_last, done, ovf, in_ready, busy} !== 8'h00) begin
      failures++;
      $display("FAIL reset: z_out,zv,zl,done,ovf,rdy,busy=%b expected 00000000",
               {z_out, z_valid, z_last, done, ovf, in_ready, busy});
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic check_pattern(input string tag, input logic [1:0] dig [N], input int nd,
                               input logic [1:0] first);
    checks++;
    if (nd !== N) begin
      failures++;
      $display("FAIL %s count: digits=%0d expected %0d", tag, nd, N);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (dig[i] !== ((i == 0) ? first : 2'b00)) begin
        failures++;
        $display("FAIL %s pattern[%0d]: %b expected %b", tag, i, dig[i], (i == 0) ? first : 2'b00);
      end
    end
  endtask

  task automatic test_positive();
    logic [1:0] d [N];
    int nd;
    run_op("positive", 6'b000100, 1'b0, -1, 0, d, nd);
    check_pattern("positive", d, nd, 2'b10);
  endtask

  task automatic test_negative();
    logic [1:0] d [N];
    int nd;
    run_op("negative", 6'b111100, 1'b0, -1, 0, d, nd);
    check_pattern("negative", d, nd, 2'b01);
  endtask

  task automatic test_zero();
    logic [1:0] d [N];
    int nd;
    run_op("zero", 6'b000000, 1'b0, -1, 0, d, nd);
    check_pattern("zero", d, nd, 2'b00);
  endtask

  task automatic test_backpressure();
    logic [1:0] d [N];
    int nd;
    run_op("stall", 6'b000100, 1'b0, 4, 3, d, nd);
    check_pattern("stall", d, nd, 2'b10);
  endtask

  task automatic test_rst_mid();
    logic [5:0] es;
    logic [1:0] ez;
    logic [1:0] d [N];
    int nd;
    cycle(1'b1, 1'b0, 6'h00, 6'h00, es, ez);
    for (int i = 0; i < DELTA + 3; i++) cycle(1'b0, 1'b1, (i == 0) ? 6'b000100 : 6'h00, 6'h00, es, ez);
    checks++;
    if ({z_valid, busy} !== 2'b11) begin
      failures++;
      $display("FAIL rst_mid digit3: zv,busy=%b expected 11", {z_valid, busy});
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    m_ph = 0; m_acc = 0; m_r = 0; m_z = 2'b00; m_ovf = 1'b0;
    checks++;
    if ({busy, z_valid, in_ready, done, ovf} !== 5'b00000) begin
      failures++;
      $display("FAIL rst_mid after: busy,zv,rdy,done,ovf=%b expected 00000",
               {busy, z_valid, in_ready, done, ovf});
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    run_op("rst_repeat", 6'b000100, 1'b0, -1, 0, d, nd);
    check_pattern("rst_repeat", d, nd, 2'b10);
  endtask

  task automatic test_random();
    logic [1:0] d [N];
    int nd;
    for (int r = 0; r < 12; r++) begin
      run_op("random", 6'h00, 1'b1, -1, 0, d, nd);
      checks++;
      if (nd !== N) begin
        failures++;
        $display("FAIL random count op%0d: digits=%0d expected %0d", r, nd, N);
      end
    end
  endtask

`ifdef OM_SEL_OVF_CHK_EN
  task automatic test_ovf();
    logic [5:0] es;
    logic [1:0] ez;
    cycle(1'b1, 1'b0, 6'h00, 6'h00, es, ez);
    for (int i = 0; i < DELTA + N; i++) cycle(1'b0, 1'b1, 6'b011000, 6'h00, es, ez);
    repeat (3) cycle(1'b0, 1'b0, 6'h00, 6'h00, es, ez);
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf sticky: ovf=%b expected 1", ovf);
    end
    cycle(1'b1, 1'b0, 6'h00, 6'h00, es, ez);
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf clear: ovf=%b expected 0", ovf);
    end
    for (int i = 0; i < DELTA + N + 1; i++) cycle(1'b0, 1'b1, 6'h00, 6'h00, es, ez);
    cycle(1'b0, 1'b0, 6'h00, 6'h00, es, ez);
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; ws_in = 6'h00; wc_in = 6'h00;
    test_reset();
    test_positive();
    test_negative();
    test_zero();
    test_backpressure();
    test_rst_mid();
    test_random();
`ifdef OM_SEL_OVF_CHK_EN
    test_ovf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
